request_unit: RTL
=================

// Module: request_unit
// PURPOSE
//   Memory-request sequencer directly downstream of the control unit in the single-cycle MIPS core.
//   - Consumes decoded MemRead/MemWrite/mem_halt/rw_flag and the ALU data address.
//   - Drives instruction/data read and write enables toward the cache interface.
//   - Produces PC_EN, so the PC and instruction advance only after every access of the instruction completes.
// PARAMETERS
//   ADDR_W   32   width of daddr and snoop_addr; link compare uses [ADDR_W-1:2]
// PORTS
//   CLK         in   1       system clock; all state updates on rising edge
//   RST         in   1       synchronous, active-high reset
//   ihit        in   1       instruction fetch complete (1-cycle pulse)
//   dhit        in   1       data access complete (1-cycle pulse)
//   MemRead     in   1       from control unit: instruction loads
//   MemWrite    in   1       from control unit: instruction stores
//   mem_halt    in   1       from control unit: instruction is HALT
//   rw_flag     in   1       from control unit: 1 marks LL (with MemRead) / SC (with MemWrite)
//   daddr       in   ADDR_W  data address from ALU
//   snoop_inv   in   1       external invalidate of snoop_addr (used only with LLSC_EN)
//   snoop_addr  in   ADDR_W  address being invalidated
//   iREN        out  1       instruction read enable
//   dREN        out  1       data read enable (registered)
//   dWEN        out  1       data write enable (registered)
//   PC_EN       out  1       combinational 1-cycle pulse: retire instruction, advance PC
//   halt        out  1       sticky halted indication (registered)
//   sc_result   out  1       SC outcome, valid in the PC_EN cycle of an SC (1 = success)
// BEHAVIOUR
//   - Reset values: state=FETCH, dREN=0, dWEN=0, halt=0, link_valid=0.
//     During RST: iREN=0, PC_EN=0, sc_result=1.
//   - FETCH: iREN=1, dREN=dWEN=0. Decoded inputs are sampled in the ihit cycle:
//       mem_halt             -> HALTED, PC_EN=0.
//       MemWrite             -> DATA, dWEN=1 next cycle, PC_EN=0 (write wins if both set; dREN stays 0).
//       MemRead (no write)   -> DATA, dREN=1 next cycle, PC_EN=0.
//       otherwise            -> PC_EN=1 same cycle, stay FETCH.
//     dhit in FETCH is ignored.
//   - DATA: iREN=0. dREN/dWEN hold the values latched on entry. Inputs are not re-sampled (datapath holds them since PC_EN=0).
//     On dhit: PC_EN=1 same cycle; dREN/dWEN cleared next cycle; -> FETCH.
//     ihit in DATA is ignored. There is no timeout; DATA waits indefinitely.
//   - HALTED: iREN=dREN=dWEN=PC_EN=0, halt=1. Left only by RST.
//   - Latency: non-memory instruction retires in the ihit cycle. Memory instruction: ihit cycle + 1 + cycles until dhit.
//   - RST mid-DATA: the pending access is abandoned. dREN/dWEN are 0 the cycle after reset; no PC_EN.
//   - Simultaneous ihit and mem_halt with MemRead/MemWrite: halt has priority, no data access.
// CONFIGURATION
//   REQUEST_UNIT_LLSC_EN defined: link register link_addr/link_valid.
//     LL (MemRead&rw_flag) on its dhit: link_addr<=daddr, link_valid<=1.
//     SC (MemWrite&rw_flag) in the FETCH ihit cycle, when !link_valid or word address != link_addr:
//       no DATA entry, dWEN stays 0, PC_EN=1, sc_result=0.
//     SC otherwise: normal store; on dhit sc_result=1, link_valid<=0.
//     Any plain store whose dhit matches link_addr clears link_valid.
//     snoop_inv with a matching snoop_addr clears link_valid in any state.
//       If it coincides with the SC's FETCH ihit, the SC fails.
//   Undefined: rw_flag, snoop_inv and snoop_addr are ignored. SC behaves as a plain store. sc_result is tied 1.
// TESTING
//   1. RST 2 cycles, ALU op, ihit -> PC_EN=1 in ihit cycle; iREN=1; dREN=dWEN=0 throughout.
//   2. LW, ihit, dhit 3 cycles later -> dREN=1 for 3 cycles; PC_EN only in dhit cycle; iREN=0 in DATA.
//   3. MemRead=MemWrite=1, ihit -> dWEN=1, dREN=0; dhit -> PC_EN=1.
//   4. HALT with MemWrite=1, ihit -> halt=1 next cycle, all enables 0; ihit/dhit pulses no effect until RST.
//   5. SW in DATA, RST pulse -> dWEN=0 and state FETCH next cycle; a dhit arriving later is ignored.
//   6. LLSC_EN: LL 0x100, SC 0x100 -> sc_result=1, dWEN pulse. LL 0x100, snoop_inv 0x100, SC 0x100 -> sc_result=0, no dWEN, PC_EN in the ihit cycle.

Source files
------------

// File: rtl/request_unit.sv
// request_unit: memory-request sequencer producing I/D enables and PC_EN for the single-cycle core.
// Optional LL/SC link tracking is enabled by defining REQUEST_UNIT_LLSC_EN.
module request_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              mem_halt,
  input  logic              rw_flag,
  input  logic [ADDR_W-1:0] daddr,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              PC_EN,
  output logic              halt,
  output logic              sc_result
);
  typedef enum logic [1:0] {FETCH, DATA, HALTED} state_t;
  state_t state;
  logic fetch_go, data_go, sc_fail;
  assign fetch_go = !RST && state == FETCH && ihit;
  assign data_go  = !RST && state == DATA && dhit;
  assign iREN     = !RST && state == FETCH;
  assign PC_EN    = (fetch_go && !mem_halt && (!(MemRead || MemWrite) || sc_fail)) || data_go;
`ifdef REQUEST_UNIT_LLSC_EN
  logic [ADDR_W-1:2] link_addr;
  logic link_valid, is_ll, snoop_hit, link_match;
  assign snoop_hit  = snoop_inv && snoop_addr[ADDR_W-1:2] == link_addr;
  assign link_match = link_valid && daddr[ADDR_W-1:2] == link_addr && !snoop_hit;
  assign sc_fail    = fetch_go && !mem_halt && MemWrite && rw_flag && !link_match;
  assign sc_result  = !sc_fail;
  // snoop clear is last so it overrides a same-cycle LL link
  always_ff @(posedge CLK)
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
      is_ll      <= 1'b0;
    end else begin
      if (fetch_go) is_ll <= MemRead && !MemWrite && rw_flag;
      if (data_go && is_ll) begin
        link_addr  <= daddr[ADDR_W-1:2];
        link_valid <= 1'b1;
      end else if (data_go && dWEN && daddr[ADDR_W-1:2] == link_addr) link_valid <= 1'b0;
      if (snoop_hit) link_valid <= 1'b0;
    end
`else
  logic unused_llsc;
  assign unused_llsc = ^{rw_flag, snoop_inv, snoop_addr, daddr};
  assign sc_fail     = 1'b0;
  assign sc_result   = 1'b1;
`endif
  always_ff @(posedge CLK)
    if (RST) begin
      state <= FETCH;
      dREN  <= 1'b0;
      dWEN  <= 1'b0;
      halt  <= 1'b0;
    end else begin
      unique case (state)
        FETCH:
          if (ihit) begin
            if (mem_halt) begin
              state <= HALTED;
              halt  <= 1'b1;
            end else if (MemWrite && !sc_fail) begin
              state <= DATA;
              dWEN  <= 1'b1;
            end else if (MemRead && !MemWrite) begin
              state <= DATA;
              dREN  <= 1'b1;
            end
          end
        DATA:
          if (dhit) begin
            state <= FETCH;
            dREN  <= 1'b0;
            dWEN  <= 1'b0;
          end
        default: begin
          dREN <= 1'b0;
          dWEN <= 1'b0;
          halt <= 1'b1;
        end
      endcase
    end
endmodule
